// File: rtl/saturn_seq_pkg.sv
// Shared types and constants for the Saturn phase sequencer.
package saturn_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    localparam int DEF_CTR_W = 32;

    function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
        return 4'b0001 << ph;
    endfunction

endpackage

// File: rtl/saturn_clk_en_div.sv
// Clock-enable divider: one registered pulse every CLK_DIV clocks (CLK_DIV in 1..16).
module saturn_clk_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic clk_en
);

    localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            clk_en <= 1'b1;
        end else begin
            cnt    <= cnt + 4'd1;
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/saturn_phase_sequencer.sv
// Saturn core timing: clock enable, 4-phase rotation, cycle counter, busy stalls.
// Debugger halt/single-step is built only with SATURN_SEQ_SINGLE_STEP_EN defined.
module saturn_phase_sequencer
    import saturn_seq_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int INIT_CYCLES = 8,
    parameter int CTR_W       = DEF_CTR_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_bus_busy,
    input  logic             i_alu_busy,
    input  logic             i_exec_unit_busy,
    input  logic             i_dbg_halt,
    input  logic             i_dbg_step,
    output logic             o_clk_en,
    output logic [1:0]       o_phase,
    output logic [3:0]       o_phases,
    output logic [CTR_W-1:0] o_cycle_ctr,
    output logic             o_stalled,
    output logic             o_halted,
    output logic             o_init_done
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

    logic             en_raw, busy;
    seq_state_t       state, state_n;
    logic [1:0]       phase_n;
    logic [CTR_W-1:0] ctr_n;
    logic             stalled_n, init_done_n, step_req, step_req_n;
    logic [IW-1:0]    init_cnt, init_cnt_n;

    saturn_clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (i_clk),
        .reset  (i_reset),
        .clk_en (en_raw)
    );

    assign busy = i_bus_busy | i_alu_busy | i_exec_unit_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_INIT;
            o_phase     <= PH0;
            o_cycle_ctr <= '0;
            o_stalled   <= 1'b0;
            o_init_done <= 1'b0;
            init_cnt    <= '0;
            step_req    <= 1'b0;
        end else begin
            state       <= state_n;
            o_phase     <= phase_n;
            o_cycle_ctr <= ctr_n;
            o_stalled   <= stalled_n;
            o_init_done <= init_done_n;
            init_cnt    <= init_cnt_n;
            step_req    <= step_req_n;
        end
    end

    // Decisions use the raw divider pulse; it equals o_clk_en everywhere but HALT.
    always_comb begin
        state_n     = state;
        phase_n     = o_phase;
        ctr_n       = o_cycle_ctr;
        stalled_n   = o_stalled;
        init_done_n = o_init_done;
        init_cnt_n  = init_cnt;
        step_req_n  = step_req;
        case (state)
            ST_INIT: begin
                if (en_raw) begin
                    if (init_cnt == INIT_LAST) begin
                        state_n     = ST_RUN;
                        init_done_n = 1'b1;
                        phase_n     = PH0;
                    end else begin
                        init_cnt_n = init_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (en_raw) begin
                    if (busy) begin
                        stalled_n = 1'b1;
                    end else begin
                        stalled_n = 1'b0;
                        phase_n   = o_phase + 2'd1;
                        if (o_phase == PH3) begin
                            ctr_n = o_cycle_ctr + CTR_W'(1);
`ifdef SATURN_SEQ_SINGLE_STEP_EN
                            if (i_dbg_halt) state_n = ST_HALT;
`endif
                        end
                    end
                end
            end
`ifdef SATURN_SEQ_SINGLE_STEP_EN
            ST_HALT: begin
                // A step pulse may land between divider wraps, so it is latched.
                if (i_dbg_step) step_req_n = 1'b1;
                if (en_raw && (!i_dbg_halt || step_req || i_dbg_step)) begin
                    state_n    = ST_RUN;
                    phase_n    = PH0;
                    step_req_n = 1'b0;
                end
            end
`endif
            default: state_n = ST_INIT;
        endcase
    end

    assign o_phases = (state == ST_RUN) ? phase_onehot(o_phase) : 4'b0000;

`ifdef SATURN_SEQ_SINGLE_STEP_EN
    assign o_clk_en = en_raw && (state != ST_HALT);
    assign o_halted = (state == ST_HALT);
`else
    logic unused_dbg;
    assign unused_dbg = i_dbg_halt ^ i_dbg_step ^ step_req;
    assign o_clk_en   = en_raw;
    assign o_halted   = 1'b0;
`endif

endmodule
